// File: rtl/pattern_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pattern_pkg : mode encodings and 3-bit RGB colour constants for pattern_gen
// Revision    : 1.0
// ---------------------------------------------------------------------------
package pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BORDER = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_BOX    = 2'd3
  } mode_e;

  // One bit per channel, {r,g,b}; widened to COLOR_W by the consumer.
  typedef logic [2:0] rgb3_t;

  localparam rgb3_t RGB_WHITE   = 3'b111;
  localparam rgb3_t RGB_YELLOW  = 3'b110;
  localparam rgb3_t RGB_CYAN    = 3'b011;
  localparam rgb3_t RGB_GREEN   = 3'b010;
  localparam rgb3_t RGB_MAGENTA = 3'b101;
  localparam rgb3_t RGB_RED     = 3'b100;
  localparam rgb3_t RGB_BLUE    = 3'b001;
  localparam rgb3_t RGB_BLACK   = 3'b000;

  function automatic rgb3_t bar_colour(input logic [2:0] k);
    rgb3_t c;
    case (k)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage : pattern_pkg
`default_nettype wire

// File: rtl/pattern_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pattern_gen_if : timing-side inputs and colour-side outputs of pattern_gen
// Revision       : 1.0
// ---------------------------------------------------------------------------
interface pattern_gen_if #(
  parameter int COLOR_W = 4
);
  logic [31:0]        x;
  logic [31:0]        y;
  logic               enable;
  logic [1:0]         mode_in;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic               valid;
  logic               frame_tick;

  modport master (
    output x, y, enable, mode_in,
    input  r, g, b, valid, frame_tick
  );

  modport slave (
    input  x, y, enable, mode_in,
    output r, g, b, valid, frame_tick
  );
endinterface : pattern_gen_if
`default_nettype wire

// File: rtl/pattern_gen_box_mover.sv
`default_nettype none
// ---------------------------------------------------------------------------
// box_mover : bouncing-box position/direction state, advanced once per frame
// Revision  : 1.0
// ---------------------------------------------------------------------------
module box_mover
  import pattern_pkg::*;
#(
  parameter int H    = 640,
  parameter int V    = 480,
  parameter int BOX  = 64,
  parameter int STEP = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        frame_end,
  input  wire logic        active,
  output logic      [31:0] bx,
  output logic      [31:0] by
);

  localparam logic [31:0] X_MAX  = 32'(H - BOX);
  localparam logic [31:0] Y_MAX  = 32'(V - BOX);
  localparam logic [31:0] STEP_U = 32'(STEP);

  // Direction bit: 1 = moving towards larger coordinates.
  logic        dx;
  logic        dy;
  logic [31:0] bx_next;
  logic [31:0] by_next;
  logic        dx_next;
  logic        dy_next;

  // Returns {new_dir, new_pos}; clamps to the wall and reverses on overshoot.
  function automatic logic [32:0] step_axis(input logic [31:0] pos,
                                            input logic        dir,
                                            input logic [31:0] lim);
    logic [32:0] res;
    if (dir) begin
      if (pos + STEP_U > lim) res = {1'b0, lim};
      else                    res = {1'b1, pos + STEP_U};
    end else begin
      if (pos < STEP_U)       res = {1'b1, 32'd0};
      else                    res = {1'b0, pos - STEP_U};
    end
    return res;
  endfunction

  always_comb begin
    {dx_next, bx_next} = step_axis(bx, dx, X_MAX);
    {dy_next, by_next} = step_axis(by, dy, Y_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bx <= '0;
      by <= '0;
      dx <= 1'b1;
      dy <= 1'b1;
    end else if (frame_end && active) begin
      bx <= bx_next;
      by <= by_next;
      dx <= dx_next;
      dy <= dy_next;
    end
  end

endmodule : box_mover
`default_nettype wire

// File: rtl/pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pattern_gen : registered RGB test-pattern source (border/bars/checker/box)
// Revision    : 1.0
// ---------------------------------------------------------------------------
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int H          = 640,
  parameter int V          = 480,
  parameter int COLOR_W    = 4,
  parameter int BORDER     = 21,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX        = 64,
  parameter int STEP       = 2
) (
  input wire logic   clk,
  input wire logic   rst,
  pattern_gen_if.slave bus
);

  localparam logic [31:0] H_U      = 32'(H);
  localparam logic [31:0] V_U      = 32'(V);
  localparam logic [31:0] X_LAST   = 32'(H - 1);
  localparam logic [31:0] Y_LAST   = 32'(V - 1);
  localparam logic [31:0] BORDER_U = 32'(BORDER);
  localparam logic [31:0] X_RIGHT  = 32'(H - 1 - BORDER);
  localparam logic [31:0] Y_BOTTOM = 32'(V - 1 - BORDER);
  localparam logic [31:0] BOX_U    = 32'(BOX);
  localparam int          BAR_W    = H / 8;

  mode_e              mode;
  logic [31:0]        bx;
  logic [31:0]        by;
  logic               last_pixel;
  logic               in_range;
  logic [6:0]         bar_ge;
  logic [2:0]         bar_k;
  rgb3_t              colour;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic               valid_q;
  logic               tick_q;

  assign last_pixel = bus.enable && (bus.x == X_LAST) && (bus.y == Y_LAST);
  assign in_range   = (bus.x < H_U) && (bus.y < V_U);

  box_mover #(
    .H    (H),
    .V    (V),
    .BOX  (BOX),
    .STEP (STEP)
  ) u_box_mover (
    .clk       (clk),
    .rst       (rst),
    .frame_end (last_pixel),
    .active    (mode == MODE_BOX),
    .bx        (bx),
    .by        (by)
  );

  // Bar index = number of bar edges at or left of x; saturates at 7 naturally.
  for (genvar i = 0; i < 7; i++) begin : g_bar
    localparam logic [31:0] EDGE = 32'((i + 1) * BAR_W);
    assign bar_ge[i] = (bus.x >= EDGE);
  end

  always_comb begin
    bar_k  = 3'd0;
    colour = RGB_BLACK;
    for (int i = 0; i < 7; i++) begin
      bar_k = bar_k + 3'(bar_ge[i]);
    end
    if (in_range) begin
      case (mode)
        MODE_BORDER: begin
          if      (bus.x < BORDER_U)  colour = RGB_WHITE;
          else if (bus.y < BORDER_U)  colour = RGB_CYAN;
          else if (bus.x > X_RIGHT)   colour = RGB_MAGENTA;
          else if (bus.y > Y_BOTTOM)  colour = RGB_YELLOW;
          else                        colour = RGB_BLUE;
        end
        MODE_BARS:  colour = bar_colour(bar_k);
        MODE_CHECK: colour = (bus.x[CHECK_LOG2] ^ bus.y[CHECK_LOG2]) ? RGB_WHITE : RGB_BLACK;
        MODE_BOX: begin
          if ((bus.x >= bx) && (bus.x < bx + BOX_U) &&
              (bus.y >= by) && (bus.y < by + BOX_U))
            colour = RGB_RED;
        end
        default: colour = RGB_BLACK;
      endcase
    end
  end

  // The mode register loads only on the last active pixel so a new pattern
  // always starts on a frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
      mode    <= MODE_BORDER;
    end else begin
      red     <= bus.enable ? {COLOR_W{colour[2]}} : '0;
      green   <= bus.enable ? {COLOR_W{colour[1]}} : '0;
      blue    <= bus.enable ? {COLOR_W{colour[0]}} : '0;
      valid_q <= bus.enable;
      tick_q  <= last_pixel;
      if (last_pixel) mode <= mode_e'(bus.mode_in);
    end
  end

  assign bus.r          = red;
  assign bus.g          = green;
  assign bus.b          = blue;
  assign bus.valid      = valid_q;
  assign bus.frame_tick = tick_q;

endmodule : pattern_gen
`default_nettype wire

// File: tb/tb_pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pattern_gen : directed, table-driven self-checking bench for pattern_gen
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_pattern_gen;
  import pattern_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_gen_if #(.COLOR_W(4)) bus ();

  pattern_gen #(
    .H          (640),
    .V          (480),
    .COLOR_W    (4),
    .BORDER     (21),
    .CHECK_LOG2 (5),
    .BOX        (64),
    .STEP       (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    x;
    int    y;
    bit    en;
    rgb3_t c;
    bit    tick;
  } vec_t;

  function automatic logic [13:0] expect_of(input rgb3_t c, input logic v, input logic t);
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}, v, t};
  endfunction

  task automatic chk(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = {bus.r, bus.g, bus.b, bus.valid, bus.frame_tick};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rgbvt=%h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input bit en);
    @(negedge clk);
    bus.x      = 32'(x);
    bus.y      = 32'(y);
    bus.enable = en;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input string name, input int x, input int y, input bit en,
                     input rgb3_t c, input bit tick);
    drive(x, y, en);
    chk(name, expect_of(c, en, tick));
  endtask

  vec_t border_tab[14];

  initial begin
    border_tab[0]  = '{5,   200, 1'b1, RGB_WHITE,   1'b0};
    border_tab[1]  = '{300, 10,  1'b1, RGB_CYAN,    1'b0};
    border_tab[2]  = '{630, 200, 1'b1, RGB_MAGENTA, 1'b0};
    border_tab[3]  = '{300, 470, 1'b1, RGB_YELLOW,  1'b0};
    border_tab[4]  = '{300, 200, 1'b1, RGB_BLUE,    1'b0};
    border_tab[5]  = '{618, 200, 1'b1, RGB_BLUE,    1'b0};
    border_tab[6]  = '{619, 200, 1'b1, RGB_MAGENTA, 1'b0};
    border_tab[7]  = '{20,  200, 1'b1, RGB_WHITE,   1'b0};
    border_tab[8]  = '{21,  200, 1'b1, RGB_BLUE,    1'b0};
    border_tab[9]  = '{300, 20,  1'b1, RGB_CYAN,    1'b0};
    border_tab[10] = '{300, 458, 1'b1, RGB_BLUE,    1'b0};
    border_tab[11] = '{300, 459, 1'b1, RGB_YELLOW,  1'b0};
    border_tab[12] = '{700, 10,  1'b1, RGB_BLACK,   1'b0};
    border_tab[13] = '{5,   5,   1'b0, RGB_BLACK,   1'b0};

    bus.x = 0; bus.y = 0; bus.enable = 1'b0; bus.mode_in = 2'd0;

    // Reset held with enable toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.enable = ~bus.enable;
      bus.x      = 32'd639;
      bus.y      = 32'd479;
      @(posedge clk);
      #1;
      chk("reset_hold", 14'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      pix($sformatf("border_vec%0d", i), border_tab[i].x, border_tab[i].y,
          border_tab[i].en, border_tab[i].c, border_tab[i].tick);
    end

    // Mid-frame mode request must wait for the frame boundary
    bus.mode_in = 2'd1;
    pix("bars_pending", 400, 200, 1'b1, RGB_BLUE, 1'b0);
    pix("frame_end_0",  639, 479, 1'b1, RGB_MAGENTA, 1'b1);
    pix("bars_x0",   0,   100, 1'b1, RGB_WHITE,   1'b0);
    pix("bars_x80",  80,  100, 1'b1, RGB_YELLOW,  1'b0);
    pix("bars_x160", 160, 100, 1'b1, RGB_CYAN,    1'b0);
    pix("bars_x240", 240, 100, 1'b1, RGB_GREEN,   1'b0);
    pix("bars_x399", 399, 100, 1'b1, RGB_MAGENTA, 1'b0);
    pix("bars_x400", 400, 100, 1'b1, RGB_RED,     1'b0);
    pix("bars_x480", 480, 100, 1'b1, RGB_BLUE,    1'b0);
    pix("bars_x639", 639, 100, 1'b1, RGB_BLACK,   1'b0);

    // Disabled last pixel: no tick, no mode load
    bus.mode_in = 2'd2;
    pix("noen_last",  639, 479, 1'b0, RGB_BLACK, 1'b0);
    pix("still_bars", 31,  0,   1'b1, RGB_WHITE, 1'b0);
    pix("frame_end_1", 639, 479, 1'b1, RGB_BLACK, 1'b1);

    pix("chk_31_0",  31, 0,  1'b1, RGB_BLACK, 1'b0);
    pix("chk_32_0",  32, 0,  1'b1, RGB_WHITE, 1'b0);
    pix("chk_32_32", 32, 32, 1'b1, RGB_BLACK, 1'b0);
    pix("chk_0_32",  0,  32, 1'b1, RGB_WHITE, 1'b0);

    bus.mode_in = 2'd3;
    pix("frame_end_2", 639, 479, 1'b1, RGB_WHITE, 1'b1);
    pix("box0_in",  0,  0, 1'b1, RGB_RED,   1'b0);
    pix("box0_out", 64, 0, 1'b1, RGB_BLACK, 1'b0);
    pix("box_frame1", 639, 479, 1'b1, RGB_BLACK, 1'b1);
    pix("box1_2_2",  2,  2, 1'b1, RGB_RED,   1'b0);
    pix("box1_1_2",  1,  2, 1'b1, RGB_BLACK, 1'b0);
    pix("box1_65_2", 65, 2, 1'b1, RGB_RED,   1'b0);
    pix("box1_66_2", 66, 2, 1'b1, RGB_BLACK, 1'b0);

    // Frames 2..288 of box motion, one last-pixel cycle each
    for (int f = 2; f <= 288; f++) drive(639, 479, 1'b1);
    pix("box288_in",    576, 258, 1'b1, RGB_RED,   1'b0);
    pix("box288_left",  575, 258, 1'b1, RGB_BLACK, 1'b0);
    pix("box288_above", 576, 257, 1'b1, RGB_BLACK, 1'b0);
    pix("box288_edge",  639, 321, 1'b1, RGB_RED,   1'b0);
    pix("box_frame289", 639, 479, 1'b1, RGB_BLACK, 1'b1);
    pix("box289_in",    576, 256, 1'b1, RGB_RED,   1'b0);
    pix("box289_left",  575, 256, 1'b1, RGB_BLACK, 1'b0);
    pix("box_frame290", 639, 479, 1'b1, RGB_BLACK, 1'b1);
    pix("box290_in",    574, 254, 1'b1, RGB_RED,   1'b0);
    pix("box290_left",  573, 254, 1'b1, RGB_BLACK, 1'b0);
    pix("box290_right", 637, 254, 1'b1, RGB_RED,   1'b0);
    pix("box290_past",  638, 254, 1'b1, RGB_BLACK, 1'b0);

    // Asynchronous reset mid-frame clears outputs before any clock edge
    drive(600, 300, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 14'd0);
    @(negedge clk);
    rst = 1'b0;
    pix("after_reset_mode0", 5, 200, 1'b1, RGB_WHITE, 1'b0);
    pix("after_reset_fend", 639, 479, 1'b1, RGB_MAGENTA, 1'b1);
    pix("after_reset_box",   0,  0, 1'b1, RGB_RED,   1'b0);
    pix("after_reset_box63", 63, 63, 1'b1, RGB_RED,  1'b0);
    pix("after_reset_box64", 64, 63, 1'b1, RGB_BLACK, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pattern_gen
`default_nettype wire
